// File: rtl/branch_hz_pkg.sv
// Shared types and constants for the ID-stage branch hazard sequencer.
package branch_hz_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_src_t;

  localparam logic [2:0] OP_BRANCH = 3'b110;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard sequencer: counts out ID-branch stalls, selects comparator
// forwarding for the resolve cycle, flushes on taken, keeps perf counters.
module branch_hazard_ctrl
  import branch_hz_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             th1,
  input  logic             th2,
  input  logic             ex_is_load,
  input  logic             mem_is_load,
  input  logic             branch_taken,
  input  logic             ext_stall,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       fwd_src,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t     state, state_n;
  logic [1:0] remain, remain_n;
  fwd_src_t   fwd_lat, fwd_lat_n;
  fwd_src_t   fwd_sel;
  logic       hz_stall, resolve;
  logic       stall_en, flush_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      remain  <= '0;
      fwd_lat <= FWD_RF;
    end else if (!ext_stall) begin
      state   <= state_n;
      remain  <= remain_n;
      fwd_lat <= fwd_lat_n;
    end
  end

  always_comb begin
    state_n   = state;
    remain_n  = remain;
    fwd_lat_n = fwd_lat;
    fwd_sel   = FWD_RF;
    hz_stall  = 1'b0;
    resolve   = 1'b0;
    unique case (state)
      RUN: begin
        if (op == OP_BRANCH) begin
          if (th1 && ex_is_load) begin
            hz_stall  = 1'b1;
            remain_n  = 2'd1;
            fwd_lat_n = FWD_MEMWB;
            state_n   = STALL;
          end else if (th1) begin
            hz_stall  = 1'b1;
            fwd_lat_n = FWD_EXMEM;
            state_n   = RESOLVE;
          end else if (th2 && mem_is_load) begin
            hz_stall  = 1'b1;
            fwd_lat_n = FWD_MEMWB;
            state_n   = RESOLVE;
          end else if (th2) begin
            resolve = 1'b1;
            fwd_sel = FWD_EXMEM;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      STALL: begin
        hz_stall = 1'b1;
        if (remain != 2'd0) remain_n = remain - 2'd1;
        if (remain <= 2'd1) state_n = RESOLVE;
      end
      RESOLVE: begin
        resolve = 1'b1;
        fwd_sel = fwd_lat;
        state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // ext_stall freezes the pipe front but must not inject bubbles or flushes;
  // fwd_src keeps tracking state so a frozen resolve holds its source.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    fwd_src     = 2'b00;
    if (rst_n) begin
      fwd_src = fwd_sel;
      if (ext_stall) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end else begin
        pc_stall    = hz_stall;
        ifid_stall  = hz_stall;
        idex_bubble = hz_stall;
        ifid_flush  = resolve & branch_taken;
      end
    end
  end

  assign stall_en = hz_stall & ~ext_stall;
  assign flush_en = resolve & branch_taken & ~ext_stall;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_en),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_branch_hazard_ctrl;

  localparam int unsigned W = 4;
  localparam logic [2:0] BR  = 3'b110;
  localparam logic [2:0] NOP = 3'b000;

  typedef struct {
    logic [5:0] ctl;
    logic [3:0] sc;
    logic [3:0] fc;
    int         id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   op;
  logic         th1, th2, ex_is_load, mem_is_load, branch_taken, ext_stall;
  logic         pc_stall, ifid_stall, idex_bubble, ifid_flush;
  logic [1:0]   fwd_src;
  logic [W-1:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;
  bit   stim_done = 1'b0;

  branch_hazard_ctrl #(.CNT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .th1          (th1),
    .th2          (th2),
    .ex_is_load   (ex_is_load),
    .mem_is_load  (mem_is_load),
    .branch_taken (branch_taken),
    .ext_stall    (ext_stall),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .fwd_src      (fwd_src),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; ctl = {pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_src}.
  task automatic cyc(input logic rst, input logic [2:0] o, input logic t1, input logic t2,
                     input logic exl, input logic meml, input logic tk, input logic xs,
                     input logic [5:0] ectl, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; op = o; th1 = t1; th2 = t2;
    ex_is_load = exl; mem_is_load = meml; branch_taken = tk; ext_stall = xs;
    e.ctl = ectl; e.sc = 4'(sc); e.fc = 4'(fc); e.id = vec_id;
    vec_id++;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_src};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl vec %0d: got %b want %b", e.id, act, e.ctl);
        end
        checks++;
        if (stall_cnt !== e.sc) begin
          errors++;
          $display("FAIL stall_cnt vec %0d: got %0d want %0d", e.id, stall_cnt, e.sc);
        end
        checks++;
        if (flush_cnt !== e.fc) begin
          errors++;
          $display("FAIL flush_cnt vec %0d: got %0d want %0d", e.id, flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0; op = NOP; th1 = 0; th2 = 0; ex_is_load = 0; mem_is_load = 0;
    branch_taken = 0; ext_stall = 0;
    // reset held, branch with hazard present: outputs must stay 0
    cyc(0, BR,  1,0,1,0,1,0, 6'b000000, 0, 0);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000000, 0, 0);
    // EX-load producer, not taken: two stalls then resolve from MEM/WB
    cyc(1, BR,  1,0,1,0,0,0, 6'b111000, 0, 0);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b111000, 1, 0);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000010, 2, 0);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000000, 2, 0);
    // EX-ALU producer, taken (taken ignored during the stall cycle)
    cyc(1, BR,  1,0,0,0,1,0, 6'b111000, 2, 0);
    cyc(1, NOP, 0,0,0,0,1,0, 6'b000101, 3, 0);
    cyc(1, NOP, 0,0,0,0,1,0, 6'b000000, 3, 1);
    // th1 beats th2/mem-load
    cyc(1, BR,  1,1,0,1,0,0, 6'b111000, 3, 1);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000001, 4, 1);
    // MEM-load producer, taken
    cyc(1, BR,  0,1,0,1,0,0, 6'b111000, 4, 1);
    cyc(1, NOP, 0,0,0,0,1,0, 6'b000110, 5, 1);
    // MEM-ALU producer, taken: resolve in the same cycle
    cyc(1, BR,  0,1,0,0,1,0, 6'b000101, 5, 2);
    cyc(1, BR,  0,0,0,0,0,0, 6'b000000, 5, 3);
    cyc(1, BR,  0,0,0,0,1,0, 6'b000100, 5, 3);
    // branch in RESOLVE ignores th*, next branch evaluated in RUN
    cyc(1, BR,  1,0,0,0,0,0, 6'b111000, 5, 4);
    cyc(1, BR,  0,1,0,0,0,0, 6'b000001, 6, 4);
    cyc(1, BR,  1,0,1,0,0,0, 6'b111000, 6, 4);
    // ext_stall for 3 cycles inside STALL
    cyc(1, NOP, 0,0,0,0,0,1, 6'b110000, 7, 4);
    cyc(1, NOP, 0,0,0,0,0,1, 6'b110000, 7, 4);
    cyc(1, NOP, 0,0,0,0,0,1, 6'b110000, 7, 4);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b111000, 7, 4);
    // frozen resolve keeps its source but suppresses the flush
    cyc(1, NOP, 0,0,0,0,1,1, 6'b110010, 8, 4);
    cyc(1, NOP, 0,0,0,0,1,0, 6'b000110, 8, 4);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000000, 8, 5);
    // ext_stall on a hazard in RUN: no transition taken
    cyc(1, BR,  1,0,1,0,0,1, 6'b110000, 8, 5);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000000, 8, 5);
    // reset mid-STALL abandons the sequence
    cyc(1, BR,  1,0,1,0,0,0, 6'b111000, 8, 5);
    cyc(0, BR,  1,0,1,0,1,0, 6'b000000, 0, 0);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000000, 0, 0);
    cyc(1, BR,  0,0,0,0,0,0, 6'b000000, 0, 0);
    // drive both counters into saturation (all-ones = 15)
    for (int i = 0; i < 17; i++) begin
      cyc(1, BR,  1,0,0,0,0,0, 6'b111000, (i > 15) ? 15 : i, (i > 15) ? 15 : i);
      cyc(1, NOP, 0,0,0,0,1,0, 6'b000101, (i + 1 > 15) ? 15 : i + 1, (i > 15) ? 15 : i);
    end
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000000, 15, 15);
    cyc(1, NOP, 0,0,0,0,0,0, 6'b000000, 15, 15);
    stim_done = 1'b1;
  end

  initial begin : finisher
    wait (stim_done);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Pipeline control sequencer that consumes the ID-stage branch hazard flags (`th1` = operand produced by the instruction in EX, `th2` = operand produced by the instruction in MEM) and drives the stall, bubble, flush and ID-branch-comparator forwarding controls. The block sits between the ID hazard detector and the PC, IF/ID and ID/EX pipeline registers. It counts out the required stall cycles, latches the forwarding source for the resolve cycle, squashes the wrong-path fetch on a taken branch, and keeps saturating performance counters.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `op` input 3: ID instruction class; `3'b110` = branch.
- `th1` input 1: branch operand depends on the EX-stage `rd`.
- `th2` input 1: branch operand depends on the MEM-stage `rd`.
- `ex_is_load` input 1: EX-stage instruction is a load.
- `mem_is_load` input 1: MEM-stage instruction is a load.
- `branch_taken` input 1: ID comparator result; valid only in a resolve cycle.
- `ext_stall` input 1: global freeze request from the memory system.
- `pc_stall` output 1: hold the PC.
- `ifid_stall` output 1: hold the IF/ID register.
- `idex_bubble` output 1: load a NOP into ID/EX.
- `ifid_flush` output 1: clear the IF/ID register.
- `fwd_src` output 2: branch operand source. `00` = register file, `01` = EX/MEM ALU result, `10` = MEM/WB data.
- `stall_cnt` output CNT_W: hazard stall cycles, saturating.
- `flush_cnt` output CNT_W: taken-branch flushes, saturating.

## Operation
- FSM states: `RUN`, `STALL`, `RESOLVE`. Registers: `state`, 2-bit `remain`, latched `fwd_lat`.
- In `RUN` with `op==3'b110`, priority is top to bottom (`th1` wins over `th2`):
  - `th1 & ex_is_load`: stall, `remain=1`, `fwd_lat=10`, go to `STALL`. Two stall cycles total.
  - `th1 & !ex_is_load`: stall, go to `RESOLVE`, `fwd_lat=01`. One stall cycle.
  - `th2 & mem_is_load`: stall, go to `RESOLVE`, `fwd_lat=10`. One stall cycle.
  - `th2 & !mem_is_load`: no stall; resolve this cycle with `fwd_src=01`.
  - Neither flag set: resolve this cycle with `fwd_src=00`.
- A stall cycle drives `pc_stall=ifid_stall=idex_bubble=1`.
- `STALL`: drives the stall outputs, decrements `remain`, and goes to `RESOLVE` once `remain` reaches 0. `th1`, `th2` and the load flags are ignored.
- `RESOLVE`: drives `fwd_src=fwd_lat` with no stall and ignores the `th*` inputs, then returns to `RUN`.
- Resolve cycle (a no-stall branch cycle in `RUN`, or `RESOLVE`): `ifid_flush = branch_taken`; `flush_cnt` increments on taken.
- Outside a resolve cycle, `fwd_src=00`, and `ifid_flush=0` regardless of `branch_taken`.
- With `op!=3'b110` in `RUN`, all control outputs are 0.
- `ext_stall=1` overrides everything:
  - `pc_stall=ifid_stall=1`, `idex_bubble=0`, `ifid_flush=0`.
  - `state`, `remain` and `fwd_lat` hold; counters hold.
  - `fwd_src` still reflects the current state, so a frozen resolve keeps its source.
- `stall_cnt` increments once per hazard stall cycle (not per `ext_stall` cycle). Both counters saturate at all-ones and never wrap.

## Timing
- Stall, bubble, flush and `fwd_src` are combinational (Mealy) from state and inputs, so the hazard stalls in the same cycle it is detected.
- State, `remain`, `fwd_lat` and the counters update on the rising `clk` edge.
- Reset (asynchronous assert, any cycle, including mid-`STALL` or `RESOLVE`):
  - `state=RUN`, `remain=0`, `fwd_lat=00`, counters 0.
  - All outputs 0 while `rst_n=0`.
  - The interrupted stall is abandoned; no resolve cycle is emitted.
- Latency from hazard detect to resolve:
  - EX-load producer: 2 stall cycles, resolve in cycle +2.
  - EX-ALU or MEM-load producer: 1 stall cycle, resolve in cycle +1.
  - MEM-ALU producer or no hazard: resolve in cycle 0.
- A branch in `RESOLVE` returns to `RUN`. A back-to-back branch behind it is evaluated on the next `RUN` cycle.

## Structure
- Package `branch_hz_pkg` holds:
  - the `state_t` enum (`RUN`, `STALL`, `RESOLVE`);
  - the `fwd_src_t` enum (`FWD_RF`, `FWD_EXMEM`, `FWD_MEMWB`);
  - the constant `OP_BRANCH = 3'b110`.
- One sub-module, `sat_counter` (parameter `W`, inputs `en` and async clear), instantiated twice for `stall_cnt` and `flush_cnt`.

## Test plan
- Branch with `th1=1`, `ex_is_load=1`, not taken: 2 cycles of `pc_stall=ifid_stall=idex_bubble=1`, then a resolve cycle with `fwd_src=10`, `ifid_flush=0`; `stall_cnt=2`.
- Branch with `th1=1`, `ex_is_load=0`, taken: 1 stall cycle, then resolve with `fwd_src=01` and `ifid_flush=1`; `stall_cnt=1`, `flush_cnt=1`.
- Branch with `th1=1`, `th2=1`, `mem_is_load=1`, `ex_is_load=0`: the EX path wins, giving 1 stall then `fwd_src=01`.
- Branch with `th2=1`, `mem_is_load=0`, taken: no stall, `fwd_src=01` and `ifid_flush=1` in the same cycle.
- `ext_stall=1` for 3 cycles during `STALL`: outputs frozen with `idex_bubble=0`, `stall_cnt` unchanged; after release the remaining stall plus resolve completes normally.
- Deassert `rst_n` during `STALL`: all outputs 0 immediately. After release, a non-branch `op` gives all outputs 0 and counters read 0. Preload counters to all-ones and confirm they hold (no wrap).
